sr_reg_bank: RTL
================

Name: sr_reg_bank

Overview:
- Parametrised bank of WIDTH independent clocked SR flip-flops, the multi-bit successor to the single-bit SR flip-flop.
- Adds a selectable policy for S=R=1, a clock enable, a parallel load, and registered per-bit rise/fall pulses.
- Adds conflict monitoring: a sticky flag plus a saturating count of conflict cycles.
- Used wherever status/flag bits are set and cleared by independent events, for example VGA timing and status flags.

Parameters:
- WIDTH, 8, number of SR bits.
- MODE, 0, S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle (JK).
- RESET_VAL, 0 (WIDTH bits), value of q after reset.
- CNT_W, 8, width of the conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  enables the SR update.
- load  in  1  parallel load of d; ignores en.
- d  in  WIDTH  parallel load data.
- s  in  WIDTH  per-bit set.
- r  in  WIDTH  per-bit reset.
- q  out  WIDTH  register state.
- q_n  out  WIDTH  always ~q.
- rise  out  WIDTH  registered 0->1 pulse per bit.
- fall  out  WIDTH  registered 1->0 pulse per bit.
- conflict  out  1  sticky: S=R=1 seen on an active update.
- conflict_clr  in  1  clears conflict and conflict_cnt.
- conflict_cnt  out  CNT_W  number of conflict cycles, saturating.

Behaviour:
- All state updates on the rising edge of clk. Every output is registered; q_n is the complement of the q register.
- Reset (rst=1 at edge), all other inputs ignored:
  - q=RESET_VAL, q_n=~RESET_VAL.
  - rise=0, fall=0, conflict=0, conflict_cnt=0.
- Priority when rst=0: load > en > hold.
- load=1: q_next=d. s, r and en are ignored. No conflict is recorded.
- load=0, en=1, per bit i:
  - s=0, r=0: hold.
  - s=1, r=0: q=1.
  - s=0, r=1: q=0.
  - s=1, r=1 (conflict bit): MODE 0 hold; MODE 1 q=1; MODE 2 q=0; MODE 3 q=~q.
- load=0, en=0: q holds. s and r are ignored. No conflict is recorded.
- rise/fall:
  - rise = ~q & q_next, registered at the same edge q updates; fall = q & ~q_next.
  - Both are valid in the same cycle as the new q and last exactly one cycle unless the bit changes again.
  - Both are 0 on any hold cycle.
- Conflict cycle: rst=0, load=0, en=1 and (s & r) != 0. One cycle counts once, regardless of how many bits conflict.
- conflict: set on a conflict cycle; cleared by conflict_clr only.
- conflict_cnt: +1 per conflict cycle; saturates at 2^CNT_W-1 with no wrap.
- conflict_clr together with a conflict cycle: set wins, giving conflict=1 and conflict_cnt=1.
- conflict_clr with no conflict: conflict=0, conflict_cnt=0.
- Reset mid-sequence: all outputs return to reset values at the next edge. Pulses pending from the previous cycle are not extended.
- No combinational input-to-output paths. Latency from input to q/rise/fall/conflict is 1 cycle.

Test Plan:
1. WIDTH=4, RESET_VAL=4'b1010, hold rst 2 cycles with s=r=4'hF, load=1 -> q=1010, q_n=0101, rise=fall=0, conflict=0, cnt=0.
2. MODE=0, en=1: s=0011,r=0 -> q=1011, rise=0001. Next cycle s=0,r=1000 -> q=0011, fall=1000, rise=0. Next cycle s=r=0 -> q=0011, rise=fall=0.
3. Conflict policy from q=0101 with s=r=0110 applied for one cycle, run once per MODE:
   - MODE 0 -> q=0101.
   - MODE 1 -> q=0111.
   - MODE 2 -> q=0001.
   - MODE 3 -> q=0011, rise=0010, fall=0100.
   - Every MODE: conflict=1, cnt=1.
4. en=0 with s=1111, r=0000 -> q unchanged. en=0 with s=r=1111 -> conflict stays 0. load=1, d=1100, en=0, s=r=1111 -> q=1100, no conflict.
5. CNT_W=2: 5 consecutive conflict cycles -> cnt 1,2,3,3,3. Then conflict_clr with no conflict -> cnt=0, conflict=0. conflict_clr with a conflict in the same cycle -> cnt=1, conflict=1.
6. After q=1111, assert rst for one cycle with s=0000, r=1111 -> q=RESET_VAL, fall=0 and rise=0 on that and the following cycle (inputs idle).

Source files
------------

// File: rtl/sr_reg_bank_if.sv
// Bus bundle for sr_reg_bank: control/data inputs and registered status outputs.
interface sr_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             conflict_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output en, load, d, s, r, conflict_clr,
    input  q, q_n, rise, fall, conflict, conflict_cnt
  );
  modport slave (
    input  en, load, d, s, r, conflict_clr,
    output q, q_n, rise, fall, conflict, conflict_cnt
  );
endinterface

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH clocked SR flip-flops with selectable S=R=1 policy, parallel
// load, registered edge pulses and a sticky/saturating conflict monitor.
module sr_lane #(
  parameter int MODE = 0
) (
  input  logic q,
  input  logic s,
  input  logic r,
  input  logic en,
  input  logic load,
  input  logic d,
  output logic q_next
);
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = d;
    end else if (en) begin
      unique case ({s, r})
        2'b10:   q_next = 1'b1;
        2'b01:   q_next = 1'b0;
        2'b11: begin
          case (MODE)
            1:       q_next = 1'b1;
            2:       q_next = 1'b0;
            3:       q_next = ~q;
            default: q_next = q;
          endcase
        end
        default: q_next = q;
      endcase
    end
  end
endmodule

module sr_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter int               MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  sr_reg_bank_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_r, q_next, rise_r, fall_r;
  logic             conflict_r, conflict_cyc;
  logic [CNT_W-1:0] cnt_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sr_lane #(.MODE(MODE)) u_lane (
      .q      (q_r[i]),
      .s      (bus.s[i]),
      .r      (bus.r[i]),
      .en     (bus.en),
      .load   (bus.load),
      .d      (bus.d[i]),
      .q_next (q_next[i])
    );
  end

  // One conflict cycle counts once no matter how many bits collide.
  assign conflict_cyc = ~bus.load & bus.en & (|(bus.s & bus.r));

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= RESET_VAL;
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      q_r    <= q_next;
      rise_r <= ~q_r & q_next;
      fall_r <= q_r & ~q_next;
    end
  end

  // A same-cycle conflict wins over clear, restarting the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_r <= 1'b0;
      cnt_r      <= '0;
    end else if (bus.conflict_clr) begin
      conflict_r <= conflict_cyc;
      cnt_r      <= conflict_cyc ? CNT_W'(1) : '0;
    end else if (conflict_cyc) begin
      conflict_r <= 1'b1;
      if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.q            = q_r;
  assign bus.q_n          = ~q_r;
  assign bus.rise         = rise_r;
  assign bus.fall         = fall_r;
  assign bus.conflict     = conflict_r;
  assign bus.conflict_cnt = cnt_r;
endmodule
